popcount_frame_accum: RTL

- Sequential stage directly downstream of the 64-bit popcount datapath.
- Consumes one 7-bit per-word popcount per beat over a valid/ready stream and accumulates counts across a frame of words delimited by in_last.
- Emits one frame-total record: bit total, word count and error flag, held under backpressure.
- Provides the reduction step for multi-word bit-vector popcount in the benchmark suite.

---
 rtl/popcount_pkg.sv | 29 ++
 rtl/popcount_out_reg.sv | 28 ++
 rtl/popcount_frame_accum.sv | 110 +++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount frame accumulator.
// Widths here are sized for the widest legal parameterisation.
package popcount_pkg;

  localparam int POPCNT_W  = 7;
  localparam int WORD_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Frame-total record, wide enough for any MAX_WORDS up to 2^15.
  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] words;
    logic        err;
  } frame_result_t;

  // Ceiling log2: bits needed to encode the values 0..value-1.
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/popcount_out_reg.sv
// Result holding register: captures one payload and holds it with
// valid asserted until the downstream handshake consumes it.
module popcount_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well so the result fields read zero after reset.
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/popcount_frame_accum.sv
// Accumulates per-word popcounts across an in_last-delimited frame and
// emits one registered frame-total record over a valid/ready interface.
module popcount_frame_accum
  import popcount_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = clog2(MAX_WORDS + 1),
  parameter int SUM_W     = clog2(WORD_BITS * MAX_WORDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [POPCNT_W-1:0] in_count,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_W-1:0]    out_sum,
  output logic [CNT_W-1:0]    out_words,
  output logic                out_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam int               PAY_W   = SUM_W + CNT_W + 1;

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   wcnt, wcnt_nxt;
  logic               err, err_nxt;

  logic               accept;
  logic               closing;
  logic               out_fire;
  logic               bad_count;
  logic               force_close;
  logic [SUM_W-1:0]   sum_beat;
  logic [CNT_W-1:0]   wcnt_inc;
  logic               err_beat;
  logic [PAY_W-1:0]   res_data;

  // Held off while a result is pending, and during the reset cycle itself.
  assign in_ready    = !rst && (state != DONE);
  assign accept      = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;

  assign sum_beat    = acc + SUM_W'(in_count);
  assign wcnt_inc    = wcnt + CNT_W'(1);
  assign bad_count   = in_count > POPCNT_W'(WORD_BITS);
  assign force_close = (wcnt_inc == MAX_CNT) && !in_last;
  assign closing     = accept && (in_last || (wcnt_inc == MAX_CNT));
  assign err_beat    = err || bad_count || force_close;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    acc_nxt   = acc;
    wcnt_nxt  = wcnt;
    err_nxt   = err;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt   = sum_beat;
          wcnt_nxt  = wcnt_inc;
          err_nxt   = err_beat;
          state_nxt = closing ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_fire) begin
          acc_nxt   = '0;
          wcnt_nxt  = '0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state <= state_nxt;
      acc   <= acc_nxt;
      wcnt  <= wcnt_nxt;
      err   <= err_nxt;
    end
  end

  // The closing beat's totals go straight into the result register.
  popcount_out_reg #(
    .W(PAY_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (closing),
    .load_data ({sum_beat, wcnt_inc, err_beat}),
    .valid     (out_valid),
    .ready     (out_ready),
    .data      (res_data)
  );

  assign {out_sum, out_words, out_err} = res_data;

endmodule
